// File: rtl/usb_upstream_arbiter_if.sv
// Upstream arbiter bundle: per-port packet requests/PISO strobes in,
// one-hot grant plus status out.
//
// Handshake: a port holds port_req high while it has a packet pending; the
// arbiter answers with a registered one-hot grant (grant_valid mirrors |grant).
// While granted, a port_val beat moves one serial bit; port_val & port_last
// closes the packet. Dropping port_req without port_val aborts the grant.
// tr_busy holds off new grants while the transceiver is still on the bus.
interface usb_upstream_arbiter_if #(
   parameter int NUM_PORTS = 2
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] port_req;
   logic [NUM_PORTS-1:0] port_val;
   logic [NUM_PORTS-1:0] port_last;
   logic                 tr_busy;
   logic [NUM_PORTS-1:0] grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_valid;
   logic                 timeout_err;
   logic [15:0]          pkt_count;
   logic [1:0]           state_dbg;

   // Device/host side: drives requests, observes the grant.
   modport master (
      output port_req, port_val, port_last, tr_busy,
      input  grant, grant_idx, grant_valid, timeout_err, pkt_count, state_dbg
   );

   // Arbiter side.
   modport slave (
      input  port_req, port_val, port_last, tr_busy,
      output grant, grant_idx, grant_valid, timeout_err, pkt_count, state_dbg
   );
endinterface

// File: rtl/usb_upstream_arbiter.sv
// Round-robin arbiter sharing one upstream USB transceiver between
// NUM_PORTS downstream PISO ports. Three-state FSM (IDLE/GRANT/TURN) with
// all outputs registered. A grant is released on packet end (counted), on
// idle timeout (timeout_err pulse) or on abort (request withdrawn).
// The idle counter starts at 0 on grant entry and the timeout fires on the
// edge after it has reached TIMEOUT_CYCLES, so an idle grant stays visible
// for TIMEOUT_CYCLES+1 cycles. A packet end in that same cycle wins.
module usb_upstream_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                  clock,
   input logic                  reset,
   usb_upstream_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
   logic                 grant_valid_q, grant_valid_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [15:0]          pkt_count_q, pkt_count_d;
   logic [15:0]          idle_cnt_q, idle_cnt_d;
   logic [IDX_W-1:0]     last_idx_q, last_idx_d;

   logic [IDX_W:0]       sum;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     sel_idx;
   logic                 found;
   logic                 g_req, g_val, g_last;

   // Only the granted port's strobes matter while in GRANT.
   assign g_req  = bus.port_req[grant_idx_q];
   assign g_val  = bus.port_val[grant_idx_q];
   assign g_last = bus.port_last[grant_idx_q];

   // Round-robin pick: scan from last_idx+1, wrapping, first requester wins.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      sum     = '0;
      cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         sum = {1'b0, last_idx_q} + (IDX_W+1)'(i) + (IDX_W+1)'(1);
         if (sum >= (IDX_W+1)'(NUM_PORTS)) sum = sum - (IDX_W+1)'(NUM_PORTS);
         cand = sum[IDX_W-1:0];
         if (!found && bus.port_req[cand]) begin
            found   = 1'b1;
            sel_idx = cand;
         end
      end
   end

   // Next-state and next-output computation for the arbiter FSM.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_err_d = 1'b0;
      pkt_count_d   = pkt_count_q;
      idle_cnt_d    = idle_cnt_q;
      last_idx_d    = last_idx_q;
      case (state_q)
         S_IDLE: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            idle_cnt_d    = '0;
            if (found && !bus.tr_busy) begin
               state_d       = S_GRANT;
               grant_d       = NUM_PORTS'(1) << sel_idx;
               grant_idx_d   = sel_idx;
               grant_valid_d = 1'b1;
            end
         end
         S_GRANT: begin
            if (g_val && g_last) begin
               state_d       = S_TURN;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               pkt_count_d   = pkt_count_q + 16'd1;
               last_idx_d    = grant_idx_q;
            end else if (idle_cnt_q == 16'(TIMEOUT_CYCLES)) begin
               state_d       = S_TURN;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               timeout_err_d = 1'b1;
               last_idx_d    = grant_idx_q;
            end else if (!g_req && !g_val) begin
               state_d       = S_TURN;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               last_idx_d    = grant_idx_q;
            end else begin
               idle_cnt_d = g_val ? 16'd0 : idle_cnt_q + 16'd1;
            end
         end
         S_TURN: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            idle_cnt_d    = '0;
            if (!bus.tr_busy) state_d = S_IDLE;
         end
         default: begin
            state_d       = S_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over any in-flight grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_err_q <= 1'b0;
         pkt_count_q   <= '0;
         idle_cnt_q    <= '0;
         last_idx_q    <= IDX_W'(NUM_PORTS - 1);
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_err_q <= timeout_err_d;
         pkt_count_q   <= pkt_count_d;
         idle_cnt_q    <= idle_cnt_d;
         last_idx_q    <= last_idx_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = grant_idx_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.pkt_count   = pkt_count_q;
   assign bus.state_dbg   = state_q;
endmodule

// File: doc/usb_upstream_arbiter.md
USB_UPSTREAM_ARBITER -- requirements
Module: usb_upstream_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of downstream device ports sharing the single upstream (host-side) transceiver.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum idle cycles inside a grant before forced release; legal range 1..65535.
REQ-003 Localparam IDX_W = max(1, clog2(NUM_PORTS)).
REQ-004 clock  input  1  single clock, low_clock domain; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 port_req  input  NUM_PORTS  per-port packet pending (device FIFO non-empty / PISO serial data available).
REQ-007 port_val  input  NUM_PORTS  per-port PISO serial bit valid.
REQ-008 port_last  input  NUM_PORTS  per-port PISO last bit of packet, qualified by port_val.
REQ-009 tr_busy  input  1  upstream transceiver still driving the bus (EOP/turnaround in progress).
REQ-010 grant  output  NUM_PORTS  one-hot grant; drives the PISO-to-transceiver mux select and per-port request enable.
REQ-011 grant_idx  output  IDX_W  binary index of granted port; valid only when grant_valid=1.
REQ-012 grant_valid  output  1  high while any port is granted.
REQ-013 timeout_err  output  1  one-cycle pulse on forced release.
REQ-014 pkt_count  output  16  completed-packet counter, wraps 0xFFFF->0x0000.

Function
REQ-015 State machine SHALL have exactly three states: IDLE, GRANT, TURN; all outputs registered.
REQ-016 IDLE: grant=0, grant_valid=0; if |port_req and !tr_busy, next edge enters GRANT with the selected port granted.
REQ-017 Selection SHALL be round-robin: search starts at (last_idx+1) mod NUM_PORTS, first set port_req bit wins.
REQ-018 Latency: port_req sampled high at edge k (IDLE, tr_busy=0) -> grant visible after edge k, i.e. one cycle.
REQ-019 GRANT: grant, grant_idx held constant; only the granted port's val/last/req are observed, all others ignored.
REQ-020 GRANT: idle counter clears on every cycle with granted port_val=1 and increments otherwise.
REQ-021 GRANT: granted port_val=1 and port_last=1 in the same cycle -> next edge: TURN, grant=0, pkt_count+1, last_idx=granted index.
REQ-022 GRANT: idle counter reaches TIMEOUT_CYCLES -> next edge: TURN, timeout_err=1 for that one cycle, last_idx=granted index, pkt_count unchanged.
REQ-023 GRANT: granted port_req drops with no port_val that cycle -> abort: TURN, last_idx updated, no timeout_err, pkt_count unchanged.
REQ-024 Simultaneous last and timeout-threshold in the same cycle: last wins (counted, no timeout_err).
REQ-025 TURN: grant=0 for at least one cycle; exits to IDLE on the first edge with tr_busy=0.
REQ-026 Minimum gap between successive grants SHALL be 2 cycles (TURN + IDLE evaluation).
REQ-027 grant SHALL never have more than one bit set; grant_valid == |grant at all times.
REQ-028 pkt_count SHALL wrap modulo 2^16 without saturation or flag.

Reset
REQ-029 reset=1 at an edge -> state IDLE, grant=0, grant_idx=0, grant_valid=0, timeout_err=0, pkt_count=0, idle counter=0, last_idx=NUM_PORTS-1 (port 0 has first priority).
REQ-030 reset asserted mid-GRANT SHALL drop grant on that same edge, no timeout_err, no pkt_count increment.

Verification
REQ-031 After reset, port_req=2'b11, tr_busy=0 -> grant=2'b01 one cycle later; port 0 sends last -> TURN, then grant=2'b10 (round-robin), pkt_count=1.
REQ-032 Port 1 granted, port_req=2'b11, port 0 val/last toggling -> grant stays 2'b10, pkt_count unchanged until port 1 last.
REQ-033 TIMEOUT_CYCLES=4, grant port 0, no port_val -> release after 4 idle cycles, timeout_err=1 for exactly one cycle, pkt_count=0.
REQ-034 Port 0 last seen while tr_busy=1 for 10 cycles -> grant=0 for all 10 cycles, new grant only after tr_busy falls.
REQ-035 Granted port last coinciding with idle counter==TIMEOUT_CYCLES -> pkt_count+1, timeout_err=0; reset pulse mid-grant -> all outputs zero next cycle.
REQ-036 Random req/val/last/tr_busy, 10k cycles, NUM_PORTS=4 -> grant one-hot-or-zero always, no port starved beyond 3 consecutive grants to others, pkt_count equals scoreboard.
